// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, execute/writeback encodings and the
// decoded bundle carried through the decode skid buffer.
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  localparam logic [5:0] E_NONE    = 6'b000000;
  localparam logic [5:0] E_ADD_IMM = 6'b000000;
  localparam logic [5:0] E_ADD_REG = 6'b000001;
  localparam logic [5:0] E_AND_IMM = 6'b010000;
  localparam logic [5:0] E_AND_REG = 6'b010001;
  localparam logic [5:0] E_NOT     = 6'b100000;
  localparam logic [5:0] E_PCREL   = 6'b000110;
  localparam logic [5:0] E_JMP     = 6'b001100;
  localparam logic [5:0] E_BASE    = 6'b001000;
  localparam logic [5:0] E_JSR_PC  = 6'b000010;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_ADDR = 2'd2,
    WB_NPC  = 2'd3
  } wsel_t;

  // npc is kept beside the bundle because its width follows PC_W
  typedef struct packed {
    logic [5:0]  e;
    wsel_t       w;
    logic        m;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] imm;
    logic        illegal;
  } bundle_t;

endpackage

// File: rtl/lc3_decode_comb.sv
// Pure combinational LC-3 instruction decoder: instruction word -> control bundle.
module lc3_decode_comb
  import lc3_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int EXT_OPS = 0
) (
  input  logic [INSTR_W-1:0] instr,
  output bundle_t            bundle
);

  opcode_t op;
  logic    imm_mode;

  assign op       = opcode_t'(instr[INSTR_W-1 -: 4]);
  assign imm_mode = instr[5];

  always_comb begin
    bundle         = '0;
    bundle.dr      = instr[11:9];
    bundle.sr1     = instr[8:6];
    bundle.sr2     = instr[2:0];
    bundle.w       = WB_ALU;
    case (op)
      OP_ADD: begin
        bundle.e = imm_mode ? E_ADD_IMM : E_ADD_REG;
        if (imm_mode) bundle.imm = {{11{instr[4]}}, instr[4:0]};
      end
      OP_AND: begin
        bundle.e = imm_mode ? E_AND_IMM : E_AND_REG;
        if (imm_mode) bundle.imm = {{11{instr[4]}}, instr[4:0]};
      end
      OP_NOT: bundle.e = E_NOT;
      OP_BR: begin
        bundle.e   = E_PCREL;
        bundle.imm = {{7{instr[8]}}, instr[8:0]};
      end
      OP_JMP: bundle.e = E_JMP;
      OP_LD: begin
        bundle.e   = E_PCREL;
        bundle.w   = WB_MEM;
        bundle.imm = {{7{instr[8]}}, instr[8:0]};
      end
      OP_LDR: begin
        bundle.e   = E_BASE;
        bundle.w   = WB_MEM;
        bundle.imm = {{10{instr[5]}}, instr[5:0]};
      end
      OP_LDI: begin
        bundle.e   = E_PCREL;
        bundle.w   = WB_MEM;
        bundle.m   = 1'b1;
        bundle.imm = {{7{instr[8]}}, instr[8:0]};
      end
      OP_LEA: begin
        bundle.e   = E_PCREL;
        bundle.w   = WB_ADDR;
        bundle.imm = {{7{instr[8]}}, instr[8:0]};
      end
      OP_ST: begin
        bundle.e   = E_PCREL;
        bundle.imm = {{7{instr[8]}}, instr[8:0]};
      end
      OP_STR: begin
        bundle.e   = E_BASE;
        bundle.imm = {{10{instr[5]}}, instr[5:0]};
      end
      OP_STI: begin
        bundle.e   = E_PCREL;
        bundle.m   = 1'b1;
        bundle.imm = {{7{instr[8]}}, instr[8:0]};
      end
      OP_JSR: begin
        if (EXT_OPS != 0) begin
          // JSR (bit 11 set) is PC-relative; JSRR jumps through a base register
          bundle.e   = instr[11] ? E_JSR_PC : E_JMP;
          bundle.w   = WB_NPC;
          bundle.imm = {{5{instr[10]}}, instr[10:0]};
        end else begin
          bundle.illegal = 1'b1;
        end
      end
      OP_TRAP: begin
        if (EXT_OPS != 0) begin
          bundle.e   = E_NONE;
          bundle.w   = WB_NPC;
          bundle.imm = {8'h00, instr[7:0]};
        end else begin
          bundle.illegal = 1'b1;
        end
      end
      default: bundle.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode_pipe.sv
// LC-3 decode stage: combinational decode feeding a two-entry skid buffer
// (output register plus skid register) with valid/ready handshakes on both sides.
module lc3_decode_pipe
  import lc3_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int EXT_OPS = 0,
  parameter int E_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [E_W-1:0]     E_Control,
  output logic [1:0]         W_Control,
  output logic               Mem_Control,
  output logic [2:0]         dr,
  output logic [2:0]         sr1,
  output logic [2:0]         sr2,
  output logic [15:0]        imm,
  output logic [PC_W-1:0]    npc,
  output logic               illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready is a pure register.

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  bundle_t         dec_b;
  logic [PC_W-1:0] dec_npc;

  bundle_t         or_b;
  bundle_t         sr_b;
  logic [PC_W-1:0] or_npc;
  logic [PC_W-1:0] sr_npc;
  logic            or_valid;
  logic            sr_valid;
  logic            in_ready_q;

  logic            accept;
  logic            or_free;
  logic            sr_valid_nxt;

  lc3_decode_comb #(
    .INSTR_W (INSTR_W),
    .EXT_OPS (EXT_OPS)
  ) u_dec (
    .instr  (instr),
    .bundle (dec_b)
  );

  assign dec_npc = pc_in + PC_ONE;
  assign accept  = in_valid & in_ready_q;
  assign or_free = ~or_valid | out_ready;

  // The skid register only fills while the output register is stalled
  always_comb begin
    sr_valid_nxt = sr_valid;
    if (or_free)     sr_valid_nxt = 1'b0;
    else if (accept) sr_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_b       <= '0;
      sr_b       <= '0;
      or_npc     <= '0;
      sr_npc     <= '0;
      or_valid   <= 1'b0;
      sr_valid   <= 1'b0;
      in_ready_q <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents so outputs hold while invalid
      or_valid   <= 1'b0;
      sr_valid   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (or_free) begin
        if (sr_valid) begin
          or_b     <= sr_b;
          or_npc   <= sr_npc;
          or_valid <= 1'b1;
        end else if (accept) begin
          or_b     <= dec_b;
          or_npc   <= dec_npc;
          or_valid <= 1'b1;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        sr_b   <= dec_b;
        sr_npc <= dec_npc;
      end
      sr_valid   <= sr_valid_nxt;
      in_ready_q <= ~sr_valid_nxt;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = or_valid;
  assign E_Control   = E_W'(or_b.e);
  assign W_Control   = or_b.w;
  assign Mem_Control = or_b.m;
  assign dr          = or_b.dr;
  assign sr1         = or_b.sr1;
  assign sr2         = or_b.sr2;
  assign imm         = or_b.imm;
  assign npc         = or_npc;
  assign illegal     = or_b.illegal;

endmodule

// File: tb/tb_lc3_decode_pipe.sv
// Directed bench for lc3_decode_pipe: one instance per EXT_OPS mode, shared stimulus.
module tb_lc3_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] instr;
  logic [15:0] pc_in;

  logic        in_ready0, out_valid0, m0, ill0;
  logic [5:0]  e0;
  logic [1:0]  w0;
  logic [2:0]  dr0, sr10, sr20;
  logic [15:0] imm0, npc0;

  logic        in_ready1, out_valid1, m1, ill1;
  logic [5:0]  e1;
  logic [1:0]  w1;
  logic [2:0]  dr1, sr11, sr21;
  logic [15:0] imm1, npc1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lc3_decode_pipe #(.INSTR_W(16), .PC_W(16), .EXT_OPS(0), .E_W(6)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .pc_in(pc_in), .out_valid(out_valid0), .out_ready(out_ready),
    .E_Control(e0), .W_Control(w0), .Mem_Control(m0), .dr(dr0), .sr1(sr10),
    .sr2(sr20), .imm(imm0), .npc(npc0), .illegal(ill0)
  );

  lc3_decode_pipe #(.INSTR_W(16), .PC_W(16), .EXT_OPS(1), .E_W(6)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .instr(instr), .pc_in(pc_in), .out_valid(out_valid1), .out_ready(out_ready),
    .E_Control(e1), .W_Control(w1), .Mem_Control(m1), .dr(dr1), .sr1(sr11),
    .sr2(sr21), .imm(imm1), .npc(npc1), .illegal(ill1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 16'h0000; pc_in = 16'h0000;
    step(); step();
    check("rst_out_valid", 32'(out_valid0), 32'h0);
    check("rst_in_ready", 32'(in_ready0), 32'h0);
    check("rst_e", 32'(e0), 32'h0);
    check("rst_imm", 32'(imm0), 32'h0);
    check("rst_npc", 32'(npc0), 32'h0);
    check("rst_illegal", 32'(ill0), 32'h0);

    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(in_ready0), 32'h1);

    // Streaming with out_ready high
    out_ready = 1'b1; in_valid = 1'b1; instr = 16'h12BD; pc_in = 16'h3000;
    step();
    check("add_valid", 32'(out_valid0), 32'h1);
    check("add_e", 32'(e0), 32'h00);
    check("add_w", 32'(w0), 32'h0);
    check("add_m", 32'(m0), 32'h0);
    check("add_dr", 32'(dr0), 32'h1);
    check("add_sr1", 32'(sr10), 32'h2);
    check("add_sr2", 32'(sr20), 32'h5);
    check("add_imm", 32'(imm0), 32'hFFFD);
    check("add_npc", 32'(npc0), 32'h3001);
    check("add_illegal", 32'(ill0), 32'h0);
    instr = 16'hA005; pc_in = 16'h3001;
    step();
    check("ldi_valid", 32'(out_valid0), 32'h1);
    check("ldi_e", 32'(e0), 32'h06);
    check("ldi_w", 32'(w0), 32'h1);
    check("ldi_m", 32'(m0), 32'h1);
    check("ldi_imm", 32'(imm0), 32'h0005);
    check("ldi_npc", 32'(npc0), 32'h3002);
    in_valid = 1'b0;
    step();
    check("idle_valid", 32'(out_valid0), 32'h0);
    check("idle_hold_e", 32'(e0), 32'h06);

    // Backpressure: three offered, two accepted
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h927F; pc_in = 16'h3100;
    step();
    check("bp_not_valid", 32'(out_valid0), 32'h1);
    check("bp_not_e", 32'(e0), 32'h20);
    check("bp_in_ready_1", 32'(in_ready0), 32'h1);
    instr = 16'hE5FE; pc_in = 16'h3101;
    step();
    check("bp_in_ready_2", 32'(in_ready0), 32'h0);
    check("bp_hold_e_2", 32'(e0), 32'h20);
    instr = 16'h7C85; pc_in = 16'h3102;
    step();
    check("bp_in_ready_3", 32'(in_ready0), 32'h0);
    check("bp_hold_e_3", 32'(e0), 32'h20);
    check("bp_hold_valid", 32'(out_valid0), 32'h1);
    out_ready = 1'b1;
    step();
    check("bp_lea_e", 32'(e0), 32'h06);
    check("bp_lea_w", 32'(w0), 32'h2);
    check("bp_lea_imm", 32'(imm0), 32'hFFFE);
    check("bp_lea_npc", 32'(npc0), 32'h3102);
    check("bp_release_in_ready", 32'(in_ready0), 32'h1);
    step();
    check("bp_str_valid", 32'(out_valid0), 32'h1);
    check("bp_str_e", 32'(e0), 32'h08);
    check("bp_str_imm", 32'(imm0), 32'h0005);
    check("bp_str_npc", 32'(npc0), 32'h3103);
    in_valid = 1'b0;
    step();
    check("bp_no_dup", 32'(out_valid0), 32'h0);

    // Flush with both entries full and an offer in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h16C4; pc_in = 16'h4000;
    step();
    instr = 16'h5A60; pc_in = 16'h4001;
    step();
    check("fl_full_in_ready", 32'(in_ready0), 32'h0);
    instr = 16'h0E03; pc_in = 16'h4002; flush = 1'b1;
    step();
    check("fl_out_valid", 32'(out_valid0), 32'h0);
    check("fl_in_ready", 32'(in_ready0), 32'h1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl_nothing_after", 32'(out_valid0), 32'h0);
    check("fl_hold_e", 32'(e0), 32'h01);

    // Flush while an accept would happen: the offered BR is dropped
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h927F; pc_in = 16'h4100;
    step();
    check("fl2_or_valid", 32'(out_valid0), 32'h1);
    instr = 16'h0E03; pc_in = 16'h4101; flush = 1'b1;
    step();
    check("fl2_out_valid", 32'(out_valid0), 32'h0);
    check("fl2_in_ready", 32'(in_ready0), 32'h1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl2_dropped", 32'(out_valid0), 32'h0);
    check("fl2_hold_e", 32'(e0), 32'h20);

    // Extended opcodes in both modes, PC wrap
    in_valid = 1'b1; instr = 16'h4802; pc_in = 16'hFFFF;
    step();
    check("jsr0_illegal", 32'(ill0), 32'h1);
    check("jsr0_e", 32'(e0), 32'h00);
    check("jsr0_w", 32'(w0), 32'h0);
    check("jsr0_valid", 32'(out_valid0), 32'h1);
    check("jsr0_npc_wrap", 32'(npc0), 32'h0000);
    check("jsr1_illegal", 32'(ill1), 32'h0);
    check("jsr1_e", 32'(e1), 32'h02);
    check("jsr1_w", 32'(w1), 32'h3);
    check("jsr1_imm", 32'(imm1), 32'h0002);
    check("jsr1_dr", 32'(dr1), 32'h4);
    instr = 16'hD000; pc_in = 16'h0010;
    step();
    check("res0_illegal", 32'(ill0), 32'h1);
    check("res1_illegal", 32'(ill1), 32'h1);
    check("res1_e", 32'(e1), 32'h00);
    check("res1_w", 32'(w1), 32'h0);
    check("res1_npc", 32'(npc1), 32'h0011);
    instr = 16'hF0FF; pc_in = 16'h0020;
    step();
    check("trap0_illegal", 32'(ill0), 32'h1);
    check("trap0_imm", 32'(imm0), 32'h0000);
    check("trap1_illegal", 32'(ill1), 32'h0);
    check("trap1_w", 32'(w1), 32'h3);
    check("trap1_imm", 32'(imm1), 32'h00FF);
    in_valid = 1'b0;
    step();

    // Reset mid-stream with the skid register full
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h927F; pc_in = 16'h5000;
    step();
    instr = 16'hE5FE; pc_in = 16'h5001;
    step();
    check("mr_sr_full", 32'(in_ready0), 32'h0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    check("mr_valid", 32'(out_valid0), 32'h0);
    check("mr_in_ready", 32'(in_ready0), 32'h0);
    check("mr_e", 32'(e0), 32'h0);
    check("mr_w", 32'(w0), 32'h0);
    check("mr_imm", 32'(imm0), 32'h0);
    check("mr_npc", 32'(npc0), 32'h0);
    rst = 1'b0; in_valid = 1'b1; instr = 16'h12BD; pc_in = 16'h5100;
    step();
    check("mr_after_in_ready", 32'(in_ready0), 32'h1);
    check("mr_after_valid", 32'(out_valid0), 32'h0);
    out_ready = 1'b1;
    step();
    check("mr_accept_valid", 32'(out_valid0), 32'h1);
    check("mr_accept_imm", 32'(imm0), 32'hFFFD);
    check("mr_accept_npc", 32'(npc0), 32'h5101);
    in_valid = 1'b0;
    step();
    check("mr_no_stale", 32'(out_valid0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
